// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential 16x16 multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_ITER  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_16_seq_if.sv
// Request/result bundle between the EX stage and the MULTU sequencer.
interface mul_16_seq_if;
  import mul_pkg::*;

  logic                   start;
  logic [MUL_WIDTH-1:0]   a;
  logic [MUL_WIDTH-1:0]   b;
  logic                   busy;
  logic                   done;
  logic [2*MUL_WIDTH-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a second
// lookahead level across groups. g_out is the whole-word generate.
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        g_out
);
  logic [15:0] g, p;
  logic [3:0]  grp_g, grp_p, gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] gg, pp, c;
    assign gg   = g[4*k +: 4];
    assign pp   = p[4*k +: 4];
    assign c[0] = gc[k];
    assign c[1] = gg[0] | (pp[0] & c[0]);
    assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
    assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & c[0]);
    assign grp_g[k] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p[k] = &pp;
    assign sum[4*k +: 4] = pp ^ c;
  end

  assign gc[0] = c_in;
  assign gc[1] = grp_g[0] | (grp_p[0] & c_in);
  assign gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_in);
  assign gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & c_in);

  assign g_out = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
endmodule

// File: rtl/mul_16_seq.sv
// Unsigned 16x16->32 shift-and-add multiplier, one cla_16 add per cycle.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips RUN and finishes in one cycle.
module mul_16_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  mul_16_seq_if.slave  bus
);
  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               last_iter;

  cla_16 u_cla (
    .a     (acc_q[2*WIDTH-1:WIDTH]),
    .b     (acc_q[0] ? mcand_q : '0),
    .c_in  (1'b0),
    .sum   (sum),
    .g_out (carry)
  );

  // 33-bit {carry,sum,low} shifted right by one; the dropped bit is the consumed multiplier bit
  assign acc_next  = {carry, sum, acc_q[WIDTH-1:1]};
  assign last_iter = (count_q == CNT_W'(MUL_ITER - 1));

`ifdef MUL_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) begin
`ifdef MUL_ZERO_BYPASS_EN
        state_d = zero_op ? DONE : RUN;
`else
        state_d = RUN;
`endif
      end
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.start) begin
          mcand_q <= bus.a;
          acc_q   <= {{WIDTH{1'b0}}, bus.b};
          count_q <= '0;
`ifdef MUL_ZERO_BYPASS_EN
          if (zero_op) product_q <= '0;
`endif
        end
        RUN: begin
          acc_q   <= acc_next;
          count_q <= count_q + 1'b1;
          if (last_iter) product_q <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_mul_16_seq.sv
// Directed bench for mul_16_seq: vector table plus collision/reset/back-to-back sequences.
module tb_mul_16_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_16_seq_if bus();

  mul_16_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts one multiply; optionally pulses start (a=7,b=7) or rst in a later cycle.
  task automatic op(input string name, input logic [15:0] av, input logic [15:0] bv,
                    input logic [31:0] exp_p, input int pulse_cyc, input int rst_cyc);
    int          exp_dc, first_dc, n_done, n_busy, n_both, held_bad;
    logic [31:0] p_at_done;
    first_dc = 0; n_done = 0; n_busy = 0; n_both = 0; held_bad = 0; p_at_done = '0;
    exp_dc = (rst_cyc > 0) ? 0 : ((BYP && (av == 0 || bv == 0)) ? 1 : 17);
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      rst = 1'b0;
      if (bus.busy) n_busy++;
      if (bus.busy && bus.done) n_both++;
      if (bus.done) begin
        n_done++;
        if (first_dc == 0) begin first_dc = c; p_at_done = bus.product; end
      end
      if (((exp_dc == 0) ? (c <= rst_cyc) : (c < exp_dc)) && bus.product !== last_p) held_bad++;
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        chk({name, " busy after rst"}, 32'(bus.busy), 32'd0);
        chk({name, " product after rst"}, bus.product, 32'd0);
      end
      if (c == pulse_cyc) begin bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd7; end
      if (c == rst_cyc) rst = 1'b1;
      if (exp_dc != 0 && c == exp_dc) break;
    end
    chk({name, " done cycle"}, 32'(first_dc), 32'(exp_dc));
    chk({name, " done count"}, 32'(n_done), (exp_dc != 0) ? 32'd1 : 32'd0);
    if (exp_dc != 0) begin
      chk({name, " product"}, p_at_done, exp_p);
      chk({name, " busy cycles"}, 32'(n_busy), (exp_dc == 17) ? 32'd16 : 32'd0);
    end
    chk({name, " old product held"}, 32'(held_bad), 32'd0);
    chk({name, " busy&done overlap"}, 32'(n_both), 32'd0);
    last_p = (exp_dc == 0) ? 32'd0 : exp_p;
  endtask

  vec_t tv[8];

  initial begin
    tv[0] = '{16'd3,    16'd5,    32'h0000_000F};
    tv[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    tv[2] = '{16'h0000, 16'hABCD, 32'h0000_0000};
    tv[3] = '{16'hABCD, 16'h0000, 32'h0000_0000};
    tv[4] = '{16'd1,    16'd1,    32'h0000_0001};
    tv[5] = '{16'hABCD, 16'd1,    32'h0000_ABCD};
    tv[6] = '{16'hFFFF, 16'd2,    32'h0001_FFFE};
    tv[7] = '{16'h00FF, 16'h0100, 32'h0000_FF00};

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy",    32'(bus.busy), 32'd0);
    chk("reset done",    32'(bus.done), 32'd0);
    chk("reset product", bus.product,   32'd0);

    // rst and start together: rst wins
    bus.start = 1'b1; bus.a = 16'd3; bus.b = 16'd5;
    @(negedge clk);
    chk("rst+start busy", 32'(bus.busy), 32'd0);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("rst+start idle", 32'(bus.busy | bus.done), 32'd0);
    last_p = '0;

    for (int i = 0; i < 8; i++)
      op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].p, 0, 0);

    op("collision", 16'h1234, 16'h0002, 32'h0000_2468, 5, 0);
    op("reset mid-op", 16'd100, 16'd200, 32'h0, 0, 8);
    op("after reset", 16'd100, 16'd200, 32'h0000_4E20, 0, 0);
    op("back-to-back", 16'h8000, 16'd2, 32'h0001_0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
